// File: rtl/parallel2serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parallel2serial_pkg
// Purpose  : Shared constants and occupancy encoding for the fft32 output
//            width converter.
// Revision : 1.0 - initial release
// ============================================================================
package parallel2serial_pkg;

    // Sample width (FFTsfpw), frame length (FFT_N) and lanes per vector.
    localparam int FFT_SFPW = 16;
    localparam int FFT_N    = 32;
    localparam int LANES    = 4;
    localparam int LANE_W   = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage : parallel2serial_pkg
`default_nettype wire

// File: rtl/parallel2serial_if.sv
`default_nettype none
// ============================================================================
// Module   : parallel2serial_if
// Purpose  : Vector-in / sample-out handshake bundle of parallel2serial.
// Revision : 1.0 - initial release
// ============================================================================
interface parallel2serial_if
    import parallel2serial_pkg::*;
#(
    parameter int NB = FFT_SFPW
);
    logic [NB*LANES-1:0] IR;
    logic [NB*LANES-1:0] II;
    logic                IVALID;
    logic                IREADY;
    logic [NB-1:0]       DR;
    logic [NB-1:0]       DI;
    logic                OVALID;
    logic                OREADY;
    logic                OLAST;
    logic [LANE_W-1:0]   OIDX;

    // Upstream producer / downstream consumer side.
    modport master (
        output IR, II, IVALID, OREADY,
        input  IREADY, DR, DI, OVALID, OLAST, OIDX
    );

    // Converter side.
    modport slave (
        input  IR, II, IVALID, OREADY,
        output IREADY, DR, DI, OVALID, OLAST, OIDX
    );
endinterface : parallel2serial_if
`default_nettype wire

// File: rtl/parallel2serial_vec_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : vec_fifo2
// Purpose  : Two-entry vector FIFO; slot 0 is always the head entry.
// Revision : 1.0 - initial release
// ============================================================================
module vec_fifo2
    import parallel2serial_pkg::*;
#(
    parameter int WIDTH = FFT_SFPW * 2 * LANES
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_din,
    output      logic [WIDTH-1:0] o_head,
    output      occ_t             o_occupancy,
    output      logic             o_full
);

    occ_t             r_occ;
    occ_t             w_occ_nxt;
    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic             w_push;
    logic             w_pop;

    // Illegal requests are dropped here so the storage can never corrupt.
    assign w_push = i_push && (r_occ != OCC_FULL);
    assign w_pop  = i_pop  && (r_occ != OCC_EMPTY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_push) w_occ_nxt = OCC_ONE;
            end
            OCC_ONE: begin
                if (w_push && !w_pop)      w_occ_nxt = OCC_FULL;
                else if (w_pop && !w_push) w_occ_nxt = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (w_pop) w_occ_nxt = OCC_ONE;
            end
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    // Shift-register storage: a pop from FULL promotes slot 1 into the head.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_push) r_slot0 <= i_din;
                end
                OCC_ONE: begin
                    if (w_push && w_pop) r_slot0 <= i_din;
                    else if (w_push)     r_slot1 <= i_din;
                end
                OCC_FULL: begin
                    if (w_pop) r_slot0 <= r_slot1;
                end
                default: begin
                    r_slot0 <= r_slot0;
                end
            endcase
        end
    end

    assign o_head      = r_slot0;
    assign o_occupancy = r_occ;
    assign o_full      = (r_occ == OCC_FULL);

endmodule : vec_fifo2
`default_nettype wire

// File: rtl/parallel2serial.sv
`default_nettype none
// ============================================================================
// Module   : parallel2serial
// Purpose  : Serialises 4-lane complex vectors into one sample per cycle and
//            flags the last sample of every FFT frame.
// Revision : 1.0 - initial release
// ============================================================================
module parallel2serial
    import parallel2serial_pkg::*;
#(
    parameter int NB    = FFT_SFPW,
    parameter int FRAME = FFT_N     // multiple of LANES
) (
    input wire logic          CLK,
    input wire logic          RST,
    parallel2serial_if.slave  bus
);

    localparam int c_vec_w   = 2 * LANES * NB;
    localparam int c_frame_w = (FRAME > 1) ? $clog2(FRAME) : 1;

    logic [c_vec_w-1:0]   w_din;
    logic [c_vec_w-1:0]   w_head;
    occ_t                 w_occ;
    logic                 w_full;
    logic                 w_ovalid;
    logic                 w_push;
    logic                 w_xfer;
    logic                 w_pop;
    logic [LANE_W-1:0]    r_lane_cnt;
    logic [c_frame_w-1:0] r_frame_cnt;
    logic [NB-1:0]        w_lane_re [LANES];
    logic [NB-1:0]        w_lane_im [LANES];

    // Imaginary half sits above the real half in each buffered entry.
    assign w_din = {bus.II, bus.IR};

    vec_fifo2 #(
        .WIDTH (c_vec_w)
    ) u_vec_fifo2 (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_din       (w_din),
        .o_head      (w_head),
        .o_occupancy (w_occ),
        .o_full      (w_full)
    );

    // IREADY depends only on registered occupancy, never on OREADY.
    assign w_ovalid = (w_occ != OCC_EMPTY);
    assign w_push   = bus.IVALID && !w_full;
    assign w_xfer   = w_ovalid && bus.OREADY;
    assign w_pop    = w_xfer && (r_lane_cnt == LANE_W'(LANES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lane_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (w_xfer) begin
            r_lane_cnt <= r_lane_cnt + 1'b1;
            if (r_frame_cnt == c_frame_w'(FRAME - 1)) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lane_re[k] = w_head[k*NB +: NB];
        assign w_lane_im[k] = w_head[(LANES + k)*NB +: NB];
    end

    assign bus.IREADY = !w_full;
    assign bus.OVALID = w_ovalid;
    assign bus.DR     = w_lane_re[r_lane_cnt];
    assign bus.DI     = w_lane_im[r_lane_cnt];
    assign bus.OIDX   = r_lane_cnt;
    assign bus.OLAST  = w_ovalid && (r_frame_cnt == c_frame_w'(FRAME - 1));

endmodule : parallel2serial
`default_nettype wire

// File: tb/tb_parallel2serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_parallel2serial
// Purpose  : Self-checking bench: queue-based reference model plus directed
//            scenarios and a randomized soak.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parallel2serial;
    import parallel2serial_pkg::*;

    localparam int NB    = 16;
    localparam int FRAME = 32;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    parallel2serial_if #(.NB(NB)) bus ();

    parallel2serial #(.NB(NB), .FRAME(FRAME)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of whole vectors and a running sample count.
    logic [2*4*NB-1:0] m_q[$];
    int  m_x        = 0;
    bit  run_chk    = 1'b0;
    int  cyc        = 0;
    int  n_xfer     = 0;
    int  olast_hits = 0;
    int  olast_at   = -1;
    int  first_x    = -1;
    int  last_x     = -1;

    always @(negedge CLK) begin : model
        logic [2*4*NB-1:0] hv;
        int  lane;
        bit  ev;
        bit  push;
        bit  xfer;
        if (run_chk) begin
            cyc++;
            ev   = (m_q.size() != 0);
            lane = m_x % 4;
            check("IREADY", bus.IREADY, m_q.size() < 2);
            check("OVALID", bus.OVALID, ev);
            check("OIDX",   bus.OIDX,   lane);
            check("OLAST",  bus.OLAST,  ev && (m_x % FRAME == FRAME - 1));
            if (ev) begin
                hv = m_q[0];
                check("DR", bus.DR, hv[lane*NB +: NB]);
                check("DI", bus.DI, hv[(4+lane)*NB +: NB]);
            end
            if (RST) begin
                m_q.delete();
                m_x        = 0;
                n_xfer     = 0;
                olast_hits = 0;
                olast_at   = -1;
                first_x    = -1;
                last_x     = -1;
            end else begin
                xfer = ev && bus.OREADY;
                push = bus.IVALID && (m_q.size() < 2);
                if (bus.OVALID && bus.OREADY) begin
                    if (bus.OLAST) begin
                        olast_hits++;
                        olast_at = n_xfer;
                    end
                    if (first_x < 0) first_x = cyc;
                    last_x = cyc;
                    n_xfer++;
                end
                if (xfer) begin
                    m_x++;
                    if (m_x % 4 == 0) void'(m_q.pop_front());
                end
                if (push) m_q.push_back({bus.II, bus.IR});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.IVALID = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic push_vec(input logic [63:0] r, input logic [63:0] i);
        bit acc;
        int n;
        bus.IR = r;
        bus.II = i;
        bus.IVALID = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = bus.IREADY;
            step();
            n++;
        end
        bus.IVALID = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus.OVALID && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (bus.OVALID) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", bus.OVALID);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] v1r, v1i, v2r, v3r, v3i;

    initial begin
        RST = 1'b1;
        bus.IVALID = 1'b0;
        bus.OREADY = 1'b1;
        bus.IR = '0;
        bus.II = '0;
        step();
        run_chk = 1'b1;
        step();
        check("rst_ovalid", bus.OVALID, 0);
        check("rst_olast",  bus.OLAST,  0);
        check("rst_oidx",   bus.OIDX,   0);
        check("rst_iready", bus.IREADY, 1);
        RST = 1'b0;

        // Single vector streams out lane by lane.
        push_vec(64'h0004_0003_0002_0001, 64'h0014_0013_0012_0011);
        for (int k = 0; k < 4; k++) begin
            check("a_ovalid", bus.OVALID, 1);
            check("a_dr",     bus.DR,     k + 1);
            check("a_di",     bus.DI,     16'h11 + k);
            check("a_oidx",   bus.OIDX,   k);
            step();
        end
        check("a_ovalid_drop", bus.OVALID, 0);

        // Nine vectors back to back: one frame plus one extra vector.
        do_reset();
        for (int v = 0; v < 9; v++) push_vec(rnd64(), rnd64());
        drain();
        check("b_olast_hits", olast_hits, 1);
        check("b_olast_at",   olast_at,   31);
        check("b_samples",    n_xfer,     36);
        check("b_contiguous", last_x - first_x, 35);

        // Backpressure after lane 1 while two more vectors arrive.
        do_reset();
        v1r = rnd64(); v1i = rnd64(); v2r = rnd64(); v3r = rnd64();
        push_vec(v1r, v1i);
        step();
        bus.OREADY = 1'b0;
        for (int h = 0; h < 5; h++) begin
            check("c_dr",   bus.DR,   v1r[31:16]);
            check("c_di",   bus.DI,   v1i[31:16]);
            check("c_oidx", bus.OIDX, 1);
            bus.IVALID = 1'b1;
            bus.IR = (h == 0) ? v2r : v3r;
            bus.II = rnd64();
            step();
        end
        check("c_iready_full", bus.IREADY, 0);
        bus.IVALID = 1'b0;
        bus.OREADY = 1'b1;
        drain();
        check("c_samples", n_xfer, 8);

        // Push coinciding with the lane-3 pop keeps occupancy at ONE.
        do_reset();
        push_vec(rnd64(), rnd64());
        step();
        step();
        step();
        check("d_oidx3", bus.OIDX, 3);
        v3r = rnd64(); v3i = rnd64();
        bus.IR = v3r; bus.II = v3i; bus.IVALID = 1'b1;
        step();
        bus.IVALID = 1'b0;
        check("d_ovalid", bus.OVALID, 1);
        check("d_oidx0",  bus.OIDX,   0);
        check("d_dr",     bus.DR,     v3r[15:0]);
        check("d_iready", bus.IREADY, 1);
        for (int c = 0; c < 20; c++) begin
            bus.IR = rnd64(); bus.II = rnd64(); bus.IVALID = 1'b1;
            step();
            check("d_cont", bus.OVALID, 1);
        end
        bus.IVALID = 1'b0;
        drain();

        // Reset while lane 2 emits with the buffer full.
        do_reset();
        push_vec(rnd64(), rnd64());
        bus.IR = rnd64(); bus.II = rnd64(); bus.IVALID = 1'b1;
        step();
        bus.IVALID = 1'b0;
        step();
        check("e_oidx2",  bus.OIDX,   2);
        check("e_full",   bus.IREADY, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("e_ovalid", bus.OVALID, 0);
        check("e_olast",  bus.OLAST,  0);
        check("e_oidx",   bus.OIDX,   0);
        check("e_iready", bus.IREADY, 1);
        v3r = rnd64(); v3i = rnd64();
        push_vec(v3r, v3i);
        check("e_dr",    bus.DR,    v3r[15:0]);
        check("e_di",    bus.DI,    v3i[15:0]);
        check("e_oidx0", bus.OIDX,  0);
        drain();

        // Randomized soak, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            RST        = ($urandom_range(0, 299) == 0);
            bus.IVALID = ($urandom_range(0, 9) < 7);
            bus.OREADY = ($urandom_range(0, 9) < 7);
            bus.IR     = rnd64();
            bus.II     = rnd64();
            step();
        end
        RST = 1'b0;
        bus.IVALID = 1'b0;
        bus.OREADY = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_parallel2serial
`default_nettype wire

// File: doc/parallel2serial.md
# parallel2serial

Output-side width converter for the fft32 pipeline: accepts 4-lane complex vectors (real and imaginary buses, nb bits per lane) from the last butterfly stage and emits them as a serial stream of one complex sample per cycle under a valid/ready handshake. A 2-entry vector buffer lets back-to-back vectors stream with no bubbles. It also marks the last sample of each FFT frame.

## Interface
- nb, 16: bits per real or imaginary sample; the value comes from the `FFTsfpw` define.
- FRAME, 32: samples per FFT frame; must be a multiple of 4.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IR  in  nb*4  real vector; lane k is at IR[nb*k +: nb]; lane 0 is the earliest sample.
- II  in  nb*4  imaginary vector; same lane packing as IR.
- IVALID  in  1  IR/II hold a valid vector.
- IREADY  out  1  block can accept a vector this cycle.
- DR  out  nb  real output sample.
- DI  out  nb  imaginary output sample.
- OVALID  out  1  DR/DI valid.
- OREADY  in  1  downstream accepts the sample.
- OLAST  out  1  DR/DI is sample FRAME-1 of the current frame.
- OIDX  out  2  lane index of the current output sample.

## Operation
- Push: on IVALID && IREADY, the vector is written to the buffer tail.
- IREADY = (occupancy != 2). It is driven from registered state only; there is no combinational path from OREADY.
- Output: DR/DI = lane[lane_cnt] of the head entry. OIDX = lane_cnt. OVALID = (occupancy != 0).
- Sample transfer: on OVALID && OREADY, lane_cnt increments and frame_cnt increments.
  - frame_cnt wraps from FRAME-1 to 0.
  - When lane_cnt is 3, lane_cnt wraps to 0 and the head entry pops.
- OLAST = OVALID && (frame_cnt == FRAME-1).
- Occupancy states and transitions:
  - EMPTY: a push moves to ONE.
  - ONE: push only moves to FULL. Pop only moves to EMPTY. Simultaneous push and pop stays in ONE, and the new vector becomes the head on the next cycle.
  - FULL: a pop moves to ONE. No push is possible because IREADY is 0.
- Backpressure: while OVALID && !OREADY, DR, DI, OIDX and OLAST hold stable and no counter moves.
- Data passes through unmodified. There is no arithmetic.
- Reset mid-operation: buffered vectors are discarded, all counters clear, and no partial vector is emitted afterwards.

## Timing
- Reset values, on the edge with RST high: occupancy=EMPTY, lane_cnt=0, frame_cnt=0.
  - Resulting outputs: OVALID=0, OLAST=0, OIDX=0, IREADY=1.
  - DR and DI are don't-care while OVALID=0, but must not be X in simulation; clear the buffer storage to 0.
- While RST is high, IVALID and OREADY are ignored.
- Latency: a vector pushed at edge N appears as lane 0 (OVALID=1) in the cycle after edge N.
- Throughput: with OREADY held at 1 and one vector pushed every 4 cycles, output is continuous at 1 sample per cycle.
- An upstream that pushes faster than this is throttled by IREADY.
- OVALID must not drop while a vector is partially emitted.
- frame_cnt counts transferred samples only, not pushed vectors.

## Structure
- `parameter.vh` holds:
  - `FFTsfpw` (nb);
  - the new define FFT_N = 32, used as the default for FRAME;
  - the lane count, 4.
- Sub-module vec_fifo2: a 2-entry, (nb*8)-bit FIFO with push, pop, head, occupancy and full outputs.
- The top level holds lane_cnt, frame_cnt, the lane mux and OLAST.

## Test plan
- Reset, then one vector with IR lanes 0..3 = 0x0001,0x0002,0x0003,0x0004 and II lanes 0..3 = 0x0011,0x0012,0x0013,0x0014, OREADY=1:
  - DR = 1,2,3,4 and DI = 0x11..0x14 on 4 consecutive cycles;
  - OIDX = 0..3; OVALID then drops.
- 8 vectors pushed whenever IREADY=1, OREADY=1:
  - 32 contiguous samples;
  - OLAST=1 only on sample 31;
  - frame_cnt wraps; a 9th vector's lane 0 has OLAST=0.
- OREADY=0 after lane 1, held 5 cycles:
  - DR, DI and OIDX=1 stable throughout;
  - after 2 pushes IREADY=0 and a third IVALID is not accepted;
  - on resume, order is preserved and nothing is lost.
- IVALID continuous with occupancy ONE:
  - the push in the same cycle as the lane-3 pop keeps occupancy at ONE;
  - the next cycle shows lane 0 of the new vector with no bubble.
- RST pulsed for 1 cycle while lane 2 is emitting with FULL occupancy:
  - next cycle OVALID=0, OLAST=0, OIDX=0, IREADY=1;
  - a fresh vector then starts at lane 0 with frame_cnt=0.
